char_emitter: RTL and testbench

- Producer end of the character display interface: buffers a queued message of ASCII bytes.
- Once started, streams the message to the 8-digit 7-segment controller, one character per pacing interval.
- Drives the controller's char_in / char_valid / clear inputs directly.
- The controller latches on the rising edge of char_valid, so every character is a distinct, spaced pulse.

---
 rtl/char_emitter.sv | 160 ++++++++++++++++
 tb/tb_char_emitter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_emitter.sv
// char_emitter
//   Producer side of the character display link. Bytes are queued in a small
//   circular FIFO; a start pulse clears the display and then streams the
//   queued bytes one at a time, each as a char_valid pulse of VALID_CYCLES
//   followed by PACE_CYCLES of low gap. The 7-segment controller latches
//   char_out on the rising edge of char_valid.
//
// Ports
//   clk        1 MHz system clock
//   rst_n      asynchronous active-low reset
//   wr_data    ASCII byte to enqueue
//   wr_en      enqueue strobe, honoured only while wr_ready=1
//   wr_ready   FIFO not full
//   start      begin streaming (single-cycle pulse, ignored while busy)
//   abort      stop streaming and flush the FIFO (single-cycle pulse)
//   busy       high whenever the FSM is not IDLE
//   level      number of bytes currently queued
//   char_out   character to the controller's char_in
//   char_valid character strobe to the controller
//   clear_out  one-cycle display clear to the controller
module char_emitter #(
    parameter int DEPTH        = 16,
    parameter int PACE_CYCLES  = 250000,
    parameter int VALID_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    output logic                       wr_ready,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 char_out,
    output logic                       char_valid,
    output logic                       clear_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PACE_CYCLES + 1);
    localparam int VW = $clog2(VALID_CYCLES + 1);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [PW-1:0] PACE_LOAD  = PW'(PACE_CYCLES - 1);
    localparam logic [VW-1:0] VALID_LOAD = VW'(VALID_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        EMIT,
        GAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] pace_cnt;
    logic [VW-1:0] valid_cnt;
    logic          push;
    logic          pop;

    assign wr_ready = (level != FULL_LEVEL);

    // abort discards a same-cycle write along with the rest of the queue.
    assign push = wr_en && wr_ready && !abort;

    // A byte is popped exactly on entry to EMIT. Entry is only reachable with
    // level>0 (CLEAR requires it, GAP checks it), so the head is always valid.
    assign pop = (next_state == EMIT) && (state != EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The GAP exit tests the registered level, so a byte written in the very
    // cycle the last gap ends stays queued instead of being streamed.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start && level != '0) next_state = CLEAR;
                CLEAR:   next_state = EMIT;
                EMIT:    if (valid_cnt == '0) next_state = GAP;
                GAP:     if (pace_cnt == '0) next_state = (level != '0) ? EMIT : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        clear_out  = (state == CLEAR);
        char_valid = (state == EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // char_out only changes on a pop, so it is stable through the pulse and
    // keeps the last character afterwards (including across an abort).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out <= 8'h00;
        end else if (pop) begin
            char_out <= mem[rd_ptr];
        end
    end

    // Both counters are loaded on entry to their phase and run down to zero;
    // the phase ends in the cycle the counter reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_cnt <= '0;
            pace_cnt  <= '0;
        end else begin
            if (pop) begin
                valid_cnt <= VALID_LOAD;
            end else if (state == EMIT && valid_cnt != '0) begin
                valid_cnt <= valid_cnt - VW'(1);
            end

            if (state == EMIT && next_state == GAP) begin
                pace_cnt <= PACE_LOAD;
            end else if (state == GAP && pace_cnt != '0) begin
                pace_cnt <= pace_cnt - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_char_emitter.sv
// tb_char_emitter
//   Self-checking bench for char_emitter with DEPTH=4, PACE_CYCLES=5,
//   VALID_CYCLES=2. A reference model tracks the message as a byte queue and
//   derives the output timeline arithmetically from the cycles elapsed since
//   the accepted start edge.
module tb_char_emitter;

    localparam int DEPTH        = 4;
    localparam int PACE_CYCLES  = 5;
    localparam int VALID_CYCLES = 2;
    localparam int PERIOD       = PACE_CYCLES + VALID_CYCLES;
    localparam int LW           = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          wr_ready;
    logic          start;
    logic          abort;
    logic          busy;
    logic [LW-1:0] level;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          clear_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queued bytes, whether a stream is running, cycles since
    // the start edge (1 = clear cycle), and the last character shown.
    logic [7:0] m_q[$];
    bit         m_busy;
    int         m_t;
    logic [7:0] m_char;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       st;
        logic       ab;
        logic       e_clear;
        logic       e_valid;
        logic [7:0] e_char;
        logic       e_busy;
        int         e_level;
    } vec_t;

    vec_t vecs[19];

    char_emitter #(
        .DEPTH(DEPTH),
        .PACE_CYCLES(PACE_CYCLES),
        .VALID_CYCLES(VALID_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_ready(wr_ready),
        .start(start),
        .abort(abort),
        .busy(busy),
        .level(level),
        .char_out(char_out),
        .char_valid(char_valid),
        .clear_out(clear_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_busy = 1'b0;
        m_t    = 0;
        m_q.delete();
        m_char = 8'h00;
    endtask

    function automatic bit modelValid();
        return m_busy && m_t >= 2 && ((m_t - 2) % PERIOD) < VALID_CYCLES;
    endfunction

    function automatic bit modelClear();
        return m_busy && m_t == 1;
    endfunction

    task automatic modelEdge(input logic we, input logic [7:0] wd, input logic st, input logic ab);
        int  sz;
        bit  gap_done;
        if (ab) begin
            m_busy = 1'b0;
            m_q.delete();
            return;
        end
        sz = m_q.size();
        if (m_busy) begin
            gap_done = (m_t >= 2) && (((m_t - 2) % PERIOD) == PERIOD - 1);
            if (gap_done && sz == 0) begin
                m_busy = 1'b0;
            end else begin
                m_t++;
                if (m_t >= 2 && ((m_t - 2) % PERIOD) == 0 && m_q.size() > 0)
                    m_char = m_q.pop_front();
            end
        end else if (st && sz > 0) begin
            m_busy = 1'b1;
            m_t    = 1;
        end
        if (we && sz < DEPTH) m_q.push_back(wd);
    endtask

    task automatic checkOutput();
        check("clear_out",  32'(clear_out),  32'(modelClear()));
        check("char_valid", 32'(char_valid), 32'(modelValid()));
        check("busy",       32'(busy),       32'(m_busy));
        check("level",      32'(level),      32'(m_q.size()));
        check("wr_ready",   32'(wr_ready),   32'(m_q.size() < DEPTH));
        check("char_out",   32'(char_out),   32'(m_char));
    endtask

    // Drives one cycle of inputs, advances the model at the edge and compares
    // at the following falling edge.
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic st, input logic ab);
        wr_en   = we;
        wr_data = wd;
        start   = st;
        abort   = ab;
        @(posedge clk);
        modelEdge(we, wd, st, ab);
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        checkOutput();
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic st,
                                input logic ec, input logic ev, input logic [7:0] ech,
                                input logic eb, input int el);
        vec_t v;
        v.we = we; v.wd = wd; v.st = st; v.ab = 1'b0;
        v.e_clear = ec; v.e_valid = ev; v.e_char = ech; v.e_busy = eb; v.e_level = el;
        return v;
    endfunction

    initial begin
        logic [7:0] got[$];
        int         rise_t[$];
        int         clears;
        int         strays;
        logic       prev_v;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        start   = 1'b0;
        abort   = 1'b0;
        modelReset();

        // Basic "HI" stream, cycle by cycle.
        vecs[0]  = mk(1, 8'h48, 0, 0, 0, 8'h00, 0, 1);
        vecs[1]  = mk(1, 8'h49, 0, 0, 0, 8'h00, 0, 2);
        vecs[2]  = mk(0, 8'h00, 1, 1, 0, 8'h00, 1, 2);
        vecs[3]  = mk(0, 8'h00, 0, 0, 1, 8'h48, 1, 1);
        vecs[4]  = mk(0, 8'h00, 0, 0, 1, 8'h48, 1, 1);
        for (int i = 5; i <= 9; i++)   vecs[i] = mk(0, 8'h00, 0, 0, 0, 8'h48, 1, 1);
        vecs[10] = mk(0, 8'h00, 0, 0, 1, 8'h49, 1, 0);
        vecs[11] = mk(0, 8'h00, 0, 0, 1, 8'h49, 1, 0);
        for (int i = 12; i <= 16; i++) vecs[i] = mk(0, 8'h00, 0, 0, 0, 8'h49, 1, 0);
        vecs[17] = mk(0, 8'h00, 0, 0, 0, 8'h49, 0, 0);
        vecs[18] = mk(0, 8'h00, 1, 0, 0, 8'h49, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        check("reset level",      32'(level),      32'd0);
        check("reset wr_ready",   32'(wr_ready),   32'd1);
        check("reset busy",       32'(busy),       32'd0);
        check("reset char_out",   32'(char_out),   32'h00);
        check("reset char_valid", 32'(char_valid), 32'd0);
        check("reset clear_out",  32'(clear_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic stream");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].st, vecs[i].ab);
            check($sformatf("vec%0d clear", i), 32'(clear_out),  32'(vecs[i].e_clear));
            check($sformatf("vec%0d valid", i), 32'(char_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d char", i),  32'(char_out),   32'(vecs[i].e_char));
            check($sformatf("vec%0d busy", i),  32'(busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d level", i), 32'(level),      32'(vecs[i].e_level));
        end

        $display("[TB] full FIFO");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
            if (i >= 3) begin
                check("full wr_ready", 32'(wr_ready), 32'd0);
                check("full level",    32'(level),    32'd4);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        prev_v = 1'b0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            if (char_valid && !prev_v) got.push_back(char_out);
            prev_v = char_valid;
        end
        check("full count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("full char%0d", i), 32'(g), 32'h31 + 32'(i));
        end
        check("full end busy", 32'(busy), 32'd0);

        $display("[TB] append mid-stream and start during gap");
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        clears = clear_out ? 1 : 0;
        prev_v = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(k == 3, 8'h42, k == 5, 1'b0);
            if (clear_out) clears++;
            if (char_valid && !prev_v) rise_t.push_back(k + 2);
            prev_v = char_valid;
        end
        check("append pulses", 32'(rise_t.size()), 32'd2);
        if (rise_t.size() == 2) begin
            check("append first rise", 32'(rise_t[0]), 32'd2);
            check("append spacing",    32'(rise_t[1] - rise_t[0]), 32'(PERIOD));
        end
        check("append clears", 32'(clears), 32'd1);
        check("append char",   32'(char_out), 32'h42);
        check("append busy",   32'(busy), 32'd0);

        $display("[TB] abort");
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (9) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("abort pre valid", 32'(char_valid), 32'd1);
        check("abort pre char",  32'(char_out),   32'h42);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        check("abort valid", 32'(char_valid), 32'd0);
        check("abort level", 32'(level),      32'd0);
        check("abort busy",  32'(busy),       32'd0);
        check("abort clear", 32'(clear_out),  32'd0);
        check("abort char",  32'(char_out),   32'h42);
        strays = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            if (char_valid || clear_out || busy) strays++;
        end
        check("abort quiet", 32'(strays), 32'd0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h53, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst pre valid", 32'(char_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", 32'(char_valid), 32'd0);
        check("arst level", 32'(level),      32'd0);
        check("arst busy",  32'(busy),       32'd0);
        check("arst char",  32'(char_out),   32'h00);
        modelReset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst start busy",  32'(busy),      32'd0);
        check("arst start clear", 32'(clear_out), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          8'($urandom),
                          1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
